sigmoid_lut_loader: RTL and testbench

// - Programmable sigmoid table: the write side that fills the activation LUT, plus the read port that serves it.
// - Accepts a stream of 2**indexLen fixed-point entries over a valid/ready handshake and stores them in order.
// - Once loaded, it answers registered sigmoid lookups with the same saturation and index rules as the hardwired sigmoid.
// - Sits between the host/config stream and the axiline datapath's activation stage.

---
 rtl/sigmoid_lut_loader_pkg.sv | 47 ++++
 rtl/sigmoid_lut_loader_if.sv | 33 +++
 rtl/sigmoid_lut_loader_mem.sv | 38 +++
 rtl/sigmoid_lut_loader.sv | 150 +++++++++++++++
 tb/tb_sigmoid_lut_loader.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_lut_loader_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_lut_loader_pkg
// Shared definitions for the programmable sigmoid table:
//   - default Q-format parameters (dataLen/indexLen/fracLen/fracIndex)
//   - FSM state encoding (EMPTY/LOAD/READY)
//   - result-select encoding used by the output stage
//   - index-slice bound and saturation-limit helpers, shared with the
//     hardwired sigmoid so both compute identical indices
// -----------------------------------------------------------------------------
package sigmoid_lut_loader_pkg;

  localparam int DATA_LEN_DEF   = 16;
  localparam int INDEX_LEN_DEF  = 6;
  localparam int FRAC_LEN_DEF   = 8;
  localparam int FRAC_INDEX_DEF = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Which value the output stage presents for the most recent lookup.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_ONE  = 2'd1,
    SEL_MEM  = 2'd2
  } sel_e;

  // Lowest input bit that lands in the table index.
  function automatic int idx_lo_bit(input int frac_len, input int frac_index);
    return frac_len - frac_index;
  endfunction

  // Highest input bit that lands in the table index (the MSB of the index is
  // the sign bit, so only indexLen-1 magnitude bits come from this slice).
  function automatic int idx_hi_bit(input int frac_len, input int frac_index,
                                    input int index_len);
    return frac_len - frac_index + index_len - 2;
  endfunction

  // Inputs beyond +/-8.0 saturate to 1.0 / 0.0.
  function automatic int sat_lim(input int frac_len);
    return 8 << frac_len;
  endfunction

endpackage

// File: rtl/sigmoid_lut_loader_if.sv
// -----------------------------------------------------------------------------
// sigmoid_lut_loader_if
// Bundles the load stream and the lookup port of the sigmoid table.
//   master : host/config side + datapath side (drives load/write/lookup)
//   slave  : sigmoid_lut_loader
// Signals: load_start, wr_valid/wr_ready/wr_data, load_done, table_valid,
//          lk_valid/lk_ready/lk_in, res_valid/res_out.
// -----------------------------------------------------------------------------
interface sigmoid_lut_loader_if #(
  parameter int DATA_LEN = 16
);
  logic                load_start;
  logic                wr_valid;
  logic                wr_ready;
  logic [DATA_LEN-1:0] wr_data;
  logic                load_done;
  logic                table_valid;
  logic                lk_valid;
  logic                lk_ready;
  logic [DATA_LEN-1:0] lk_in;
  logic                res_valid;
  logic [DATA_LEN-1:0] res_out;

  modport master (
    output load_start, wr_valid, wr_data, lk_valid, lk_in,
    input  wr_ready, load_done, table_valid, lk_ready, res_valid, res_out
  );

  modport slave (
    input  load_start, wr_valid, wr_data, lk_valid, lk_in,
    output wr_ready, load_done, table_valid, lk_ready, res_valid, res_out
  );
endinterface

// File: rtl/sigmoid_lut_loader_mem.sv
// -----------------------------------------------------------------------------
// sigmoid_lut_mem
// 2**INDEX_LEN x DATA_LEN table storage: one write port, one synchronous
// read port. No reset on contents or read data; the owner gates their use.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable (read register holds when low)
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// -----------------------------------------------------------------------------
module sigmoid_lut_mem #(
  parameter int DATA_LEN  = 16,
  parameter int INDEX_LEN = 6
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [INDEX_LEN-1:0] waddr_i,
  input  logic [DATA_LEN-1:0]  wdata_i,
  input  logic                 re_i,
  input  logic [INDEX_LEN-1:0] raddr_i,
  output logic [DATA_LEN-1:0]  rdata_o
);

  logic [DATA_LEN-1:0] mem_q [2**INDEX_LEN];

  // Table write and registered read; read data holds between lookups.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/sigmoid_lut_loader.sv
// -----------------------------------------------------------------------------
// sigmoid_lut_loader
// Programmable sigmoid table: loads 2**INDEX_LEN entries over a valid/ready
// stream, then serves registered sigmoid lookups with +/-8.0 saturation.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of sigmoid_lut_loader_if (load stream + lookups)
// -----------------------------------------------------------------------------
module sigmoid_lut_loader
  import sigmoid_lut_loader_pkg::*;
#(
  parameter int DATA_LEN   = DATA_LEN_DEF,
  parameter int INDEX_LEN  = INDEX_LEN_DEF,
  parameter int FRAC_LEN   = FRAC_LEN_DEF,
  parameter int FRAC_INDEX = FRAC_INDEX_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sigmoid_lut_loader_if.slave   bus
);

  localparam int IDX_LO = idx_lo_bit(FRAC_LEN, FRAC_INDEX);
  localparam int IDX_HI = idx_hi_bit(FRAC_LEN, FRAC_INDEX, INDEX_LEN);
  localparam logic signed [DATA_LEN-1:0] SAT_POS = DATA_LEN'(sat_lim(FRAC_LEN));
  localparam logic signed [DATA_LEN-1:0] SAT_NEG = -SAT_POS;
  localparam logic [DATA_LEN-1:0]  ONE_VAL   = DATA_LEN'(1) << FRAC_LEN;
  localparam logic [INDEX_LEN-1:0] LAST_ADDR = {INDEX_LEN{1'b1}};

  state_e                 state_q;
  logic [INDEX_LEN-1:0]   wr_addr_q;
  logic                   load_done_q;
  logic                   table_valid_q;
  logic                   res_valid_q;
  sel_e                   sel_q;
  sel_e                   sel_d;
  logic                   wr_ready;
  logic                   lk_ready;
  logic                   wr_fire;
  logic                   lk_fire;
  logic [INDEX_LEN-1:0]   lk_idx;
  logic signed [DATA_LEN-1:0] lk_signed;
  logic [DATA_LEN-1:0]    mem_rdata;
  logic [DATA_LEN-1:0]    res_out;

  // load_start has priority over both ports so a restart never races a write
  // or produces a result from a table that is about to be invalidated.
  assign wr_ready  = (state_q == ST_LOAD)  & ~bus.load_start;
  assign lk_ready  = (state_q == ST_READY) & ~bus.load_start;
  assign wr_fire   = bus.wr_valid & wr_ready;
  assign lk_fire   = bus.lk_valid & lk_ready;
  assign lk_signed = signed'(bus.lk_in);
  // Index MSB is the sign; low bits are the integer/fraction slice around 0.
  assign lk_idx    = {bus.lk_in[DATA_LEN-1], bus.lk_in[IDX_HI:IDX_LO]};

  sigmoid_lut_mem #(
    .DATA_LEN  (DATA_LEN),
    .INDEX_LEN (INDEX_LEN)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_addr_q),
    .wdata_i (bus.wr_data),
    .re_i    (lk_fire),
    .raddr_i (lk_idx),
    .rdata_o (mem_rdata)
  );

  // Saturation decision for the lookup currently on the port.
  always_comb begin
    sel_d = SEL_MEM;
    if (lk_signed < SAT_NEG) begin
      sel_d = SEL_ZERO;
    end else if (lk_signed > SAT_POS) begin
      sel_d = SEL_ONE;
    end else begin
      sel_d = SEL_MEM;
    end
  end

  // Load FSM: state, write address, load_done pulse and table_valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      wr_addr_q     <= '0;
      load_done_q   <= 1'b0;
      table_valid_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        ST_EMPTY, ST_READY: begin
          if (bus.load_start) begin
            state_q       <= ST_LOAD;
            wr_addr_q     <= '0;
            table_valid_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (bus.load_start) begin
            wr_addr_q <= '0;
          end else if (wr_fire) begin
            wr_addr_q <= wr_addr_q + INDEX_LEN'(1);
            if (wr_addr_q == LAST_ADDR) begin
              state_q       <= ST_READY;
              load_done_q   <= 1'b1;
              table_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q       <= ST_EMPTY;
          wr_addr_q     <= '0;
          table_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result stage: select travels with the synchronous memory read, so the
  // output and res_valid line up; select holds so res_out holds too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      sel_q       <= SEL_ZERO;
    end else begin
      res_valid_q <= lk_fire;
      if (lk_fire) begin
        sel_q <= sel_d;
      end
    end
  end

  // Output mux; SEL_ZERO after reset keeps res_out at 0 despite unreset RAM.
  always_comb begin
    res_out = '0;
    case (sel_q)
      SEL_ZERO: res_out = '0;
      SEL_ONE:  res_out = ONE_VAL;
      SEL_MEM:  res_out = mem_rdata;
      default:  res_out = '0;
    endcase
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.lk_ready    = lk_ready;
  assign bus.load_done   = load_done_q;
  assign bus.table_valid = table_valid_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_out     = res_out;

endmodule

// File: tb/tb_sigmoid_lut_loader.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_lut_loader
// Directed + randomized bench for sigmoid_lut_loader. The expected result of
// every lookup comes from a behavioural model: an array holding whatever the
// bench streamed in, indexed by sign and floor(x/32) mod 32, with saturation
// beyond +/-2048.
// -----------------------------------------------------------------------------
module tb_sigmoid_lut_loader;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] model [64];
  logic [15:0] exp_hold;

  sigmoid_lut_loader_if #(.DATA_LEN(16)) bus ();

  sigmoid_lut_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sigmoid from the table-lookup rules.
  function automatic logic [15:0] ref_sig(input logic [15:0] x);
    int v;
    int idx;
    v = int'($signed(x));
    if (v < -2048) return 16'd0;
    if (v > 2048)  return 16'd256;
    idx = (v < 0 ? 32 : 0) + ((v >>> 5) & 31);
    return model[idx];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_ready"},    {31'd0, bus.wr_ready},    32'd0);
    check({tag, "_lk_ready"},    {31'd0, bus.lk_ready},    32'd0);
    check({tag, "_load_done"},   {31'd0, bus.load_done},   32'd0);
    check({tag, "_table_valid"}, {31'd0, bus.table_valid}, 32'd0);
    check({tag, "_res_valid"},   {31'd0, bus.res_valid},   32'd0);
    check({tag, "_res_out"},     {16'd0, bus.res_out},     32'd0);
  endtask

  // Pulse load_start, then stream n_hs entries (mult*i) with random gaps.
  task automatic run_load(input int n_hs, input int mult);
    int hs;
    int done_cnt;
    int done_at;
    int cyc;
    bit done_tv;
    hs = 0; done_cnt = 0; done_at = -1; cyc = 0; done_tv = 1'b0;
    bus.load_start = 1'b1;
    bus.wr_valid   = 1'b0;
    bus.lk_valid   = 1'b0;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    while (hs < n_hs && cyc < 2000) begin
      bus.wr_valid = ($urandom_range(0, 3) != 0);
      bus.wr_data  = 16'(mult * hs);
      #1;
      if (bus.wr_valid && bus.wr_ready) begin
        model[hs] = bus.wr_data;
        hs++;
      end
      @(posedge clk); #1;
      if (bus.load_done) begin
        done_cnt++;
        done_at = hs;
        done_tv = bus.table_valid;
      end
      cyc++;
    end
    bus.wr_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.load_done) done_cnt++;
    end
    check("load_handshakes", 32'(hs), 32'(n_hs));
    if (n_hs == 64) begin
      check("load_done_count", 32'(done_cnt), 32'd1);
      check("load_done_at", 32'(done_at), 32'd64);
      check("table_valid_with_done", {31'd0, done_tv}, 32'd1);
      check("wr_ready_after_load", {31'd0, bus.wr_ready}, 32'd0);
      check("table_valid_after_load", {31'd0, bus.table_valid}, 32'd1);
    end else begin
      check("partial_no_done", 32'(done_cnt), 32'd0);
      check("partial_table_invalid", {31'd0, bus.table_valid}, 32'd0);
    end
  endtask

  // One lookup cycle: drive, check lk_ready, check result one edge later.
  task automatic lookup_step(input string tag, input logic [15:0] v, input bit go,
                             input logic [15:0] exp);
    bus.lk_valid = go;
    bus.lk_in    = v;
    #1;
    check({tag, "_lk_ready"}, {31'd0, bus.lk_ready}, 32'd1);
    @(posedge clk); #1;
    if (go) exp_hold = exp;
    check({tag, "_res_valid"}, {31'd0, bus.res_valid}, {31'd0, go});
    check({tag, "_res_out"}, {16'd0, bus.res_out}, {16'd0, exp_hold});
  endtask

  initial begin
    logic [15:0] v;
    bit go;
    checks = 0; failures = 0; exp_hold = 16'd0;
    rst_n = 1'b0;
    bus.load_start = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = 16'd0;
    bus.lk_valid = 1'b0; bus.lk_in = 16'd0;
    #3;
    check_idle_outputs("in_reset");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    // Writes outside LOAD have no effect.
    bus.wr_valid = 1'b1; bus.wr_data = 16'hBEEF;
    repeat (3) begin
      #1;
      check("empty_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
      @(posedge clk); #1;
      check("empty_load_done", {31'd0, bus.load_done}, 32'd0);
    end
    bus.wr_valid = 1'b0;

    run_load(64, 4);

    // Directed lookups, back-to-back, including boundaries.
    lookup_step("lk_0060",  16'sh0060, 1'b1, 16'd12);
    lookup_step("lk_FFA0",  16'shFFA0, 1'b1, 16'd244);
    lookup_step("lk_p2049", 16'd2049,  1'b1, 16'd256);
    lookup_step("lk_m2049", 16'hF7FF,  1'b1, 16'd0);
    lookup_step("lk_p2048", 16'd2048,  1'b1, 16'd0);
    lookup_step("lk_m2048", 16'hF800,  1'b1, ref_sig(16'hF800));
    lookup_step("lk_idle",  16'sh0060, 1'b0, 16'd0);

    // Random lookups with random gaps.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) v = 16'($urandom_range(0, 65535));
      else v = 16'($urandom_range(0, 4096) - 2048);
      go = ($urandom_range(0, 3) != 0);
      lookup_step("lk_rand", v, go, ref_sig(v));
    end

    // Restart: 10 entries, then load_start mid-load and a full load.
    run_load(10, 7);
    run_load(64, 4);
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom_range(0, 4096) - 2048);
      lookup_step("lk_reload", v, 1'b1, ref_sig(v));
    end
    lookup_step("lk_last", 16'sh0060, 1'b1, 16'd12);

    // Collision: load_start with a lookup in READY.
    bus.load_start = 1'b1; bus.lk_valid = 1'b1; bus.lk_in = 16'sh0060;
    #1;
    check("coll_lk_ready", {31'd0, bus.lk_ready}, 32'd0);
    @(posedge clk); #1;
    bus.load_start = 1'b0; bus.lk_valid = 1'b0;
    check("coll_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("coll_table_valid", {31'd0, bus.table_valid}, 32'd0);
    check("coll_res_hold", {16'd0, bus.res_out}, 32'd12);
    #1;
    check("coll_wr_ready", {31'd0, bus.wr_ready}, 32'd1);

    // Asynchronous reset mid-cycle while in LOAD.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_hold = 16'd0;
    #1 rst_n = 1'b1;
    bus.wr_valid = 1'b1;
    @(posedge clk); #1;
    check("post_reset_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    check("post_reset_lk_ready", {31'd0, bus.lk_ready}, 32'd0);
    check("post_reset_table_valid", {31'd0, bus.table_valid}, 32'd0);
    bus.wr_valid = 1'b0;

    // Full reload after reset, new data.
    run_load(64, 3);
    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom_range(0, 4096) - 2048);
      lookup_step("lk_final", v, 1'b1, ref_sig(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
